i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter DEV_ADDR, default 7'h50, the 7-bit target address it responds to.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-004 The block SHALL have port scl_in, input, 1, the raw bus SCL level, asynchronous to clk.
REQ-005 The block SHALL have port sda_in, input, 1, the raw bus SDA level, asynchronous to clk.
REQ-006 The block SHALL have port sda_oe, output, 1, which pulls SDA low when 1 and releases SDA (open-drain) when 0.
REQ-007 The block SHALL have port wr_valid, output, 1, a one-clk pulse marking a register write.
REQ-008 The block SHALL have port wr_addr, output, 4, the register index for the current write.
REQ-009 The block SHALL have port wr_data, output, 8, the register data for the current write.
REQ-010 The block SHALL have port rd_addr, output, 4, which always equals the current register pointer.
REQ-011 The block SHALL have port rd_data, input, 8, holding the register contents at rd_addr, valid in the same cycle.
REQ-012 The block SHALL have port busy, output, 1, which is high from an address match until STOP, repeated START or NACK release.

Function
REQ-013 scl_in and sda_in SHALL each pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized value for edge detection.
REQ-014 START SHALL be detected when synchronized SDA falls while synchronized SCL is high; STOP SHALL be detected when SDA rises while SCL is high.
REQ-015 Data bits SHALL be sampled on the synchronized SCL rising edge, MSB first; sda_oe SHALL change only on the synchronized SCL falling edge, except for START/STOP handling.
REQ-016 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 IDLE SHALL go to ADDR on START; any state SHALL go to ADDR on START (repeated START) and to IDLE on STOP, with sda_oe=0 in the same cycle.
REQ-018 ADDR SHALL shift 8 bits; on the 8th SCL fall, if bits[7:1]==DEV_ADDR, the block SHALL go to ADDR_ACK with sda_oe=1, latch R/W=bit0 and set busy=1; otherwise it SHALL go to IDLE with sda_oe=0.
REQ-019 On the SCL fall that ends ADDR_ACK, a write (R/W=0) SHALL go to WDATA with sda_oe=0 and first_byte=1.
REQ-020 On the SCL fall that ends ADDR_ACK, a read (R/W=1) SHALL load the shift register from rd_data, drive its MSB inverted onto sda_oe, and go to RDATA.
REQ-021 WDATA SHALL shift 8 bits and, on the 8th SCL fall, go to WDATA_ACK with sda_oe=1.
REQ-022 On the 8th WDATA byte, if first_byte=1 the pointer SHALL be set to byte[3:0] (bits[7:4] ignored) and first_byte cleared.
REQ-023 On the 8th WDATA byte, if first_byte=0 the block SHALL pulse wr_valid for one clk with wr_addr=pointer and wr_data=byte, then increment the pointer mod 16 (15 wraps to 0).
REQ-024 The SCL fall ending WDATA_ACK SHALL release sda_oe and return to WDATA.
REQ-025 In RDATA, the block SHALL drive sda_oe = ~bit on each SCL fall, and after 8 bits go to RDATA_ACK with sda_oe=0 and the pointer incremented mod 16.
REQ-026 In RDATA_ACK, on SCL rise, SDA=0 (controller ACK) SHALL mark a continue; on the following SCL fall the block SHALL reload from rd_data at the new pointer and enter RDATA.
REQ-027 In RDATA_ACK, SDA=1 (NACK) SHALL send the FSM to IDLE with sda_oe=0 and busy=0.
REQ-028 A 3-bit bit counter SHALL clear on START and on every state entry, and SHALL count SCL rises.
REQ-029 The pointer SHALL persist across transactions and change only per REQ-022, REQ-023, REQ-025 and reset.
REQ-030 If START and STOP are detected in the same cycle, which is impossible on a legal bus, START SHALL take priority.

Reset
REQ-031 On reset=1, state SHALL be IDLE and sda_oe, wr_valid, busy, wr_addr, wr_data, pointer, bit counter, shift register and first_byte SHALL all be 0.
REQ-032 The synchronizer flops SHALL reset to 1 (bus idle), so no false START follows reset.
REQ-033 A reset asserted mid-transfer SHALL release SDA in the next cycle, and the block SHALL ignore bus activity until the next START.

Verification
REQ-034 The bench SHALL drive START, 0xA0, 0x03, 0x5A, 0xC3, STOP -> ACK on all 4 bytes; wr_valid pulses (3,0x5A) then (4,0xC3); rd_addr=5 afterwards.
REQ-035 The bench SHALL drive START, 0xA0, 0x0F, 0x11, 0x22, STOP -> writes (15,0x11) then (0,0x22), showing wrap-around.
REQ-036 The bench SHALL drive START, 0xA0, 0x02, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP with rd_data model reg[i]=i*0x10 -> SDA returns 0x20, 0x30; sda_oe=0 after NACK; busy=0.
REQ-037 The bench SHALL drive START, 0xB0 (address mismatch), 8 more bits, STOP -> sda_oe stays 0, busy stays 0, wr_valid never pulses.
REQ-038 The bench SHALL assert reset during the 4th bit of a read byte -> sda_oe=0 in the next clk, state IDLE, and a following valid write transaction works normally.
REQ-039 The bench SHALL drive STOP after the 3rd bit of a write data byte -> no wr_valid pulse, state IDLE, pointer unchanged.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a 16-entry register pointer: the first written byte sets the pointer, later bytes write and auto-increment.
// Bus pins pass through a 2-flop synchronizer, so events are acted on 3 clk after the pin edge; SCL stretching is not used.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [3:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t      state;
  logic [2:0]  scl_q, sda_q;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [3:0]  ptr;
  logic        rw, first_byte, byte_done, ack_cont;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_q[1];
  assign scl_p     = scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_p     = sda_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign rd_addr   = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= 4'd0;
      wr_data    <= 8'd0;
      busy       <= 1'b0;
      ptr        <= 4'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      byte_done  <= 1'b0;
      ack_cont   <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        ack_cont  <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        ack_cont  <= 1'b0;
      end else begin
        // The 3-bit counter wraps after 8 rises; byte_done marks the fall that closes the byte.
        if (scl_rise && (state == ADDR || state == WDATA || state == RDATA)) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            byte_done <= 1'b1;
          if (state != RDATA)
            shreg <= {shreg[6:0], sda_s};
        end
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_fall && byte_done) begin
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
              if (shreg[7:1] == DEV_ADDR) begin
                state  <= ADDR_ACK;
                sda_oe <= 1'b1;
                rw     <= shreg[0];
                busy   <= 1'b1;
              end else begin
                state  <= IDLE;
                sda_oe <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
              if (!rw) begin
                state      <= WDATA;
                sda_oe     <= 1'b0;
                first_byte <= 1'b1;
              end else begin
                state  <= RDATA;
                shreg  <= rd_data;
                sda_oe <= ~rd_data[7];
              end
            end
          end
          WDATA: begin
            if (scl_fall && byte_done) begin
              state     <= WDATA_ACK;
              sda_oe    <= 1'b1;
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
              if (first_byte) begin
                ptr        <= shreg[3:0];
                first_byte <= 1'b0;
              end else begin
                wr_valid <= 1'b1;
                wr_addr  <= ptr;
                wr_data  <= shreg;
                ptr      <= ptr + 4'd1;
              end
            end
          end
          WDATA_ACK: begin
            if (scl_fall) begin
              state     <= WDATA;
              sda_oe    <= 1'b0;
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (byte_done) begin
                state     <= RDATA_ACK;
                sda_oe    <= 1'b0;
                ptr       <= ptr + 4'd1;
                bit_cnt   <= 3'd0;
                byte_done <= 1'b0;
                ack_cont  <= 1'b0;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_cont <= 1'b1;
              end else begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end
            end else if (scl_fall && ack_cont) begin
              state     <= RDATA;
              shreg     <= rd_data;
              sda_oe    <= ~rd_data[7];
              bit_cnt   <= 3'd0;
              byte_done <= 1'b0;
              ack_cont  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller drives the bus and expected writes are queued for the monitor.
module tb_i2c_target;

  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_c = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, busy;
  logic [3:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic saw_oe = 1'b0;
  logic saw_busy = 1'b0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  assign sda_bus = sda_c & ~sda_oe;
  assign rd_data = {rd_addr, 4'h0};

  i2c_target #(.DEV_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_bus),
    .sda_oe(sda_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      saw_oe   <= saw_oe | sda_oe;
      saw_busy <= saw_busy | busy;
      if (wr_valid) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
          check("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_c = 1'b1; hq(); scl = 1'b1; hq(); sda_c = 1'b0; hq(); scl = 1'b0; hq();
  endtask

  task automatic i2c_stop();
    sda_c = 1'b0; hq(); scl = 1'b1; hq(); sda_c = 1'b1; hq();
  endtask

  task automatic write_bit(input logic b);
    sda_c = b; hq(); scl = 1'b1; hq(); hq(); scl = 1'b0; hq();
  endtask

  task automatic read_bit(output logic b);
    sda_c = 1'b1; hq(); scl = 1'b1; hq(); b = sda_bus; hq(); scl = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(nack);
  endtask

  initial begin
    logic ack, b;
    logic [7:0] d;
    int wc;

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_rd_addr", {28'd0, rd_addr}, 32'd0);

    // Pointer 3, two writes
    exp_q.push_back({4'd3, 8'h5A});
    exp_q.push_back({4'd4, 8'hC3});
    i2c_start();
    write_byte(8'hA0, ack); check("t1_ack_addr", {31'd0, ack}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    write_byte(8'h03, ack); check("t1_ack_ptr", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, ack); check("t1_ack_d0", {31'd0, ack}, 32'd0);
    write_byte(8'hC3, ack); check("t1_ack_d1", {31'd0, ack}, 32'd0);
    i2c_stop(); hq();
    check("t1_rd_addr", {28'd0, rd_addr}, 32'd5);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Pointer wrap 15 -> 0
    exp_q.push_back({4'd15, 8'h11});
    exp_q.push_back({4'd0, 8'h22});
    i2c_start();
    write_byte(8'hA0, ack); check("t2_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h0F, ack); check("t2_ack_ptr", {31'd0, ack}, 32'd0);
    write_byte(8'h11, ack); check("t2_ack_d0", {31'd0, ack}, 32'd0);
    write_byte(8'h22, ack); check("t2_ack_d1", {31'd0, ack}, 32'd0);
    i2c_stop(); hq();
    check("t2_rd_addr", {28'd0, rd_addr}, 32'd1);

    // Set pointer 2, repeated START, read two bytes
    i2c_start();
    write_byte(8'hA0, ack); check("t3_ack_addr", {31'd0, ack}, 32'd0);
    write_byte(8'h02, ack); check("t3_ack_ptr", {31'd0, ack}, 32'd0);
    i2c_start();
    write_byte(8'hA1, ack); check("t3_ack_raddr", {31'd0, ack}, 32'd0);
    read_byte(d, 1'b0); check("t3_rd0", {24'd0, d}, 32'h20);
    read_byte(d, 1'b1); check("t3_rd1", {24'd0, d}, 32'h30);
    hq();
    check("t3_sda_oe_nack", {31'd0, sda_oe}, 32'd0);
    check("t3_busy_nack", {31'd0, busy}, 32'd0);
    i2c_stop(); hq();
    check("t3_rd_addr", {28'd0, rd_addr}, 32'd4);

    // Address mismatch
    saw_oe = 1'b0; saw_busy = 1'b0; wc = wr_count;
    i2c_start();
    write_byte(8'hB0, ack); check("t4_nack_addr", {31'd0, ack}, 32'd1);
    write_byte(8'h00, ack);
    i2c_stop(); hq();
    check("t4_saw_oe", {31'd0, saw_oe}, 32'd0);
    check("t4_saw_busy", {31'd0, saw_busy}, 32'd0);
    check("t4_wr_count", wr_count, wc);

    // Reset during the 4th bit of a read byte (reg[6] = 0x60)
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h06, ack);
    i2c_start();
    write_byte(8'hA1, ack); check("t5_ack_raddr", {31'd0, ack}, 32'd0);
    read_bit(b); check("t5_b7", {31'd0, b}, 32'd0);
    read_bit(b); check("t5_b6", {31'd0, b}, 32'd1);
    read_bit(b); check("t5_b5", {31'd0, b}, 32'd1);
    sda_c = 1'b1; hq(); scl = 1'b1; hq();
    check("t5_oe_before", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_oe_after", {31'd0, sda_oe}, 32'd0);
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    check("t5_rd_addr_after", {28'd0, rd_addr}, 32'd0);
    hq(); scl = 1'b0; hq();
    check("t5_oe_idle", {31'd0, sda_oe}, 32'd0);
    i2c_stop(); hq();
    exp_q.push_back({4'd5, 8'h99});
    i2c_start();
    write_byte(8'hA0, ack); check("t5_ack_addr2", {31'd0, ack}, 32'd0);
    write_byte(8'h05, ack); check("t5_ack_ptr2", {31'd0, ack}, 32'd0);
    write_byte(8'h99, ack); check("t5_ack_d2", {31'd0, ack}, 32'd0);
    i2c_stop(); hq();
    check("t5_rd_addr_end", {28'd0, rd_addr}, 32'd6);

    // STOP after 3 bits of a data byte
    wc = wr_count;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h09, ack); check("t6_ack_ptr", {31'd0, ack}, 32'd0);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
    i2c_stop(); hq();
    check("t6_wr_count", wr_count, wc);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_rd_addr", {28'd0, rd_addr}, 32'd9);
    check("t6_sda_oe", {31'd0, sda_oe}, 32'd0);

    repeat (10) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
